// File: rtl/fifo_to_axis_if.sv
// AXI4-Stream bundle driven by fifo_to_axis.
// Ports: tdata/tstrb/tuser/tlast/tvalid from master, tready from slave.
interface fifo_to_axis_if #(
   parameter int DATA_WIDTH  = 256,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;

   modport master (
      output tdata, tstrb, tuser, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tuser, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/fifo_to_axis.sv
// Rebuilds AXIS beats from a FWFT FIFO of header + data words.
// Ports: axi_aclk, axi_reset (async), sw_rst (sync), FIFO read side,
//   m_axis master stream (tdata/tstrb/tuser/tvalid/tready/tlast).
module fifo_to_axis #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DATA_WIDTH      = 32
) (
   input  logic                         axi_aclk,
   input  logic                         axi_reset,
   input  logic                         sw_rst,
   output logic                         fifo_rd_en,
   input  logic [FIFO_DATA_WIDTH-1:0]   fifo_dout,
   input  logic [FIFO_DATA_WIDTH/8-1:0] fifo_dout_strb,
   input  logic                         fifo_empty,
   fifo_to_axis_if.master               m_axis
);
   localparam int DW        = C_M_AXIS_DATA_WIDTH;
   localparam int UW        = C_M_AXIS_TUSER_WIDTH;
   localparam int FW        = FIFO_DATA_WIDTH;
   localparam int WPB       = DW / FW;
   localparam int HDR_WORDS = UW / FW;
   localparam int FB        = FW / 8;
   localparam int IW        = (WPB > 1) ? $clog2(WPB) : 1;
   localparam int HW        = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

   localparam logic [15:0]   FB16     = 16'(FB);
   localparam logic [IW-1:0] IDX_LAST = IW'(WPB - 1);
   localparam logic [HW-1:0] HDR_LAST = HW'(HDR_WORDS - 1);

   typedef enum logic {HDR, DATA} state_t;

   state_t            state;
   logic [HW-1:0]     hdr_cnt;
   logic [IW-1:0]     idx;
   logic [15:0]       bytes_rem;
   logic [DW-1:0]     build_data;
   logic [DW/8-1:0]   build_strb;
   logic              build_full;
   logic              build_last;
   logic [UW-1:0]     tuser_reg;

   logic [UW-1:0]     hdr_next;
   logic [DW-1:0]     data_next;
   logic [DW/8-1:0]   strb_next;
   logic              word_last;
   logic              beat_done;
   logic              out_free;

   // A held beat in the build buffer blocks all popping, which also
   // keeps the next header out of tuser_reg until that beat leaves.
   assign fifo_rd_en = !fifo_empty && !build_full &&
                       !axi_reset && !sw_rst;
   assign out_free   = !m_axis.tvalid || m_axis.tready;

   always_comb begin
      hdr_next  = tuser_reg;
      hdr_next[hdr_cnt*FW +: FW] = fifo_dout;
      data_next = build_data;
      data_next[idx*FW +: FW] = fifo_dout;
      strb_next = build_strb;
      strb_next[idx*FB +: FB] = fifo_dout_strb;
      word_last = (bytes_rem <= FB16);
      beat_done = word_last || (idx == IDX_LAST);
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state         <= HDR;
         hdr_cnt       <= '0;
         idx           <= '0;
         bytes_rem     <= '0;
         build_data    <= '0;
         build_strb    <= '0;
         build_full    <= 1'b0;
         build_last    <= 1'b0;
         tuser_reg     <= '0;
         m_axis.tdata  <= '0;
         m_axis.tstrb  <= '0;
         m_axis.tuser  <= '0;
         m_axis.tvalid <= 1'b0;
         m_axis.tlast  <= 1'b0;
      end else if (sw_rst) begin
         state         <= HDR;
         hdr_cnt       <= '0;
         idx           <= '0;
         bytes_rem     <= '0;
         build_data    <= '0;
         build_strb    <= '0;
         build_full    <= 1'b0;
         build_last    <= 1'b0;
         tuser_reg     <= '0;
         m_axis.tdata  <= '0;
         m_axis.tstrb  <= '0;
         m_axis.tuser  <= '0;
         m_axis.tvalid <= 1'b0;
         m_axis.tlast  <= 1'b0;
      end else begin
         if (m_axis.tvalid && m_axis.tready)
            m_axis.tvalid <= 1'b0;

         if (build_full && out_free) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= build_data;
            m_axis.tstrb  <= build_strb;
            m_axis.tlast  <= build_last;
            m_axis.tuser  <= tuser_reg;
            build_full    <= 1'b0;
            build_data    <= '0;
            build_strb    <= '0;
         end

         // fifo_rd_en implies the build buffer is empty here.
         if (fifo_rd_en) begin
            unique case (state)
               HDR: begin
                  tuser_reg <= hdr_next;
                  if (hdr_cnt == HDR_LAST) begin
                     hdr_cnt   <= '0;
                     bytes_rem <= hdr_next[15:0];
                     if (hdr_next[15:0] != 16'd0)
                        state <= DATA;
                  end else begin
                     hdr_cnt <= hdr_cnt + 1'b1;
                  end
               end
               DATA: begin
                  bytes_rem <= word_last ? 16'd0 : bytes_rem - FB16;
                  if (beat_done) begin
                     idx <= '0;
                     if (word_last)
                        state <= HDR;
                     // Free output: bypass the build buffer entirely.
                     if (out_free) begin
                        m_axis.tvalid <= 1'b1;
                        m_axis.tdata  <= data_next;
                        m_axis.tstrb  <= strb_next;
                        m_axis.tlast  <= word_last;
                        m_axis.tuser  <= tuser_reg;
                        build_data    <= '0;
                        build_strb    <= '0;
                     end else begin
                        build_full <= 1'b1;
                        build_last <= word_last;
                        build_data <= data_next;
                        build_strb <= strb_next;
                     end
                  end else begin
                     idx        <= idx + 1'b1;
                     build_data <= data_next;
                     build_strb <= strb_next;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis with a queue-backed FWFT FIFO.
// Beats are captured at negedge and checked against a word-pattern model.
module tb_fifo_to_axis;
   localparam int DW = 256;
   localparam int UW = 128;
   localparam int FW = 32;

   logic          axi_aclk = 1'b0;
   logic          axi_reset = 1'b1;
   logic          sw_rst = 1'b0;
   logic          fifo_rd_en;
   logic [31:0]   fifo_dout = '0;
   logic [3:0]    fifo_dout_strb = '0;
   logic          fifo_empty = 1'b1;

   int nvec = 0;
   int nerr = 0;

   fifo_to_axis_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_axis ();

   fifo_to_axis #(
      .C_M_AXIS_DATA_WIDTH(DW),
      .C_M_AXIS_TUSER_WIDTH(UW),
      .FIFO_DATA_WIDTH(FW)
   ) dut (
      .axi_aclk(axi_aclk),
      .axi_reset(axi_reset),
      .sw_rst(sw_rst),
      .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout),
      .fifo_dout_strb(fifo_dout_strb),
      .fifo_empty(fifo_empty),
      .m_axis(m_axis)
   );

   always #5 axi_aclk = ~axi_aclk;

   // FIFO model: stimulus only appends, the popper only advances rd_ptr.
   logic [35:0] fq[$];
   int rd_ptr = 0;

   always @(posedge axi_aclk) begin : popper
      logic take;
      take = fifo_rd_en && !fifo_empty;
      #1;
      if (take) rd_ptr = rd_ptr + 1;
      if (rd_ptr < fq.size()) begin
         fifo_empty     = 1'b0;
         fifo_dout      = fq[rd_ptr][31:0];
         fifo_dout_strb = fq[rd_ptr][35:32];
      end else begin
         fifo_empty     = 1'b1;
         fifo_dout      = '0;
         fifo_dout_strb = '0;
      end
   end

   logic [DW-1:0]   b_data[$];
   logic [DW/8-1:0] b_strb[$];
   logic [UW-1:0]   b_user[$];
   logic            b_last[$];

   always @(negedge axi_aclk) begin
      if (m_axis.tvalid && m_axis.tready) begin
         b_data.push_back(m_axis.tdata);
         b_strb.push_back(m_axis.tstrb);
         b_user.push_back(m_axis.tuser);
         b_last.push_back(m_axis.tlast);
      end
   end

   function automatic logic [31:0] dword(int p, int i);
      return {p[7:0], 8'h5A, i[15:0]};
   endfunction

   function automatic logic [UW-1:0] exp_tuser(int p, int len);
      logic [UW-1:0] u;
      u[31:0] = {p[7:0], 8'hC3, len[15:0]};
      for (int k = 1; k < 4; k++)
         u[k*32 +: 32] = {p[7:0], k[7:0], 16'hBEEF};
      return u;
   endfunction

   function automatic logic [DW-1:0] exp_data(int p, int nw, int b);
      logic [DW-1:0] d;
      d = '0;
      for (int l = 0; l < 8; l++)
         if (b*8 + l < nw) d[l*32 +: 32] = dword(p, b*8 + l);
      return d;
   endfunction

   task automatic send(int p, int len, logic [3:0] lstrb, int maxw);
      logic [UW-1:0] u;
      int nw;
      u  = exp_tuser(p, len);
      nw = (len + 3) / 4;
      for (int k = 0; k < 4; k++)
         fq.push_back({4'h0, u[k*32 +: 32]});
      for (int i = 0; i < nw && i < maxw; i++)
         fq.push_back({(i == nw-1) ? lstrb : 4'hF, dword(p, i)});
   endtask

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge axi_aclk);
      #2;
   endtask

   task automatic wait_beats(string tag, int base, int n);
      for (int i = 0; i < 200 && b_data.size() < base + n; i++) step();
      repeat (6) step();
      chk(tag, 256'(b_data.size() - base), 256'(n));
   endtask

   task automatic chk_beat(string tag, int bi, int p, int len, int b,
                           logic [31:0] strb, logic last);
      if (bi >= b_data.size()) begin
         chk({tag, "_missing"}, 256'(b_data.size()), 256'(bi + 1));
      end else begin
         chk({tag, "_data"}, b_data[bi], exp_data(p, (len + 3) / 4, b));
         chk({tag, "_strb"}, 256'(b_strb[bi]), 256'(strb));
         chk({tag, "_last"}, 256'(b_last[bi]), 256'(last));
         chk({tag, "_user"}, 256'(b_user[bi]), 256'(exp_tuser(p, len)));
      end
   endtask

   initial begin : stim
      int base;
      int p0;
      logic [DW-1:0] snap_d;
      logic [UW-1:0] snap_u;

      m_axis.tready = 1'b1;
      send(1, 60, 4'hF, 99);
      repeat (3) step();
      chk("rst_tvalid", 256'(m_axis.tvalid), 256'(0));
      chk("rst_tlast", 256'(m_axis.tlast), 256'(0));
      chk("rst_tdata", m_axis.tdata, 256'(0));
      chk("rst_tuser", 256'(m_axis.tuser), 256'(0));
      chk("rst_rd_en", 256'(fifo_rd_en), 256'(0));

      // len=60: two beats, 19 pops
      base = 0;
      axi_reset = 1'b0;
      wait_beats("t1_count", base, 2);
      chk_beat("t1_b0", base, 1, 60, 0, 32'hFFFF_FFFF, 1'b0);
      chk_beat("t1_b1", base + 1, 1, 60, 1, 32'h0FFF_FFFF, 1'b1);
      chk("t1_pops", 256'(rd_ptr), 256'(19));

      // len=65: three beats, last beat one byte
      base = b_data.size();
      send(2, 65, 4'h1, 99);
      wait_beats("t2_count", base, 3);
      chk_beat("t2_b2", base + 2, 2, 65, 2, 32'h0000_0001, 1'b1);
      if (base + 2 < b_data.size())
         chk("t2_upper", 256'(b_data[base+2][255:32]), 256'(0));

      // backpressure: len=60 then len=4 queued behind it
      base = b_data.size();
      p0 = rd_ptr;
      m_axis.tready = 1'b0;
      send(3, 60, 4'hF, 99);
      send(4, 4, 4'hF, 99);
      for (int i = 0; i < 100 && !m_axis.tvalid; i++) step();
      chk("t3_tvalid", 256'(m_axis.tvalid), 256'(1));
      snap_d = m_axis.tdata;
      snap_u = m_axis.tuser;
      repeat (20) step();
      chk("t3_pops", 256'(rd_ptr - p0), 256'(19));
      chk("t3_rd_en", 256'(fifo_rd_en), 256'(0));
      chk("t3_hold_d", m_axis.tdata, snap_d);
      chk("t3_hold_u", 256'(m_axis.tuser), 256'(snap_u));
      chk("t3_hold_d_exp", m_axis.tdata, exp_data(3, 15, 0));
      m_axis.tready = 1'b1;
      wait_beats("t3_count", base, 3);
      chk_beat("t3_b0", base, 3, 60, 0, 32'hFFFF_FFFF, 1'b0);
      chk_beat("t3_b1", base + 1, 3, 60, 1, 32'h0FFF_FFFF, 1'b1);
      chk_beat("t3_b2", base + 2, 4, 4, 0, 32'h0000_000F, 1'b1);

      // back-to-back len=32 then len=4
      base = b_data.size();
      send(5, 32, 4'hF, 99);
      send(6, 4, 4'hF, 99);
      wait_beats("t4_count", base, 2);
      chk_beat("t4_b0", base, 5, 32, 0, 32'hFFFF_FFFF, 1'b1);
      chk_beat("t4_b1", base + 1, 6, 4, 0, 32'h0000_000F, 1'b1);

      // len=0 header dropped, then len=8
      base = b_data.size();
      send(7, 0, 4'hF, 99);
      send(8, 8, 4'hF, 99);
      wait_beats("t5_count", base, 1);
      chk_beat("t5_b0", base, 8, 8, 0, 32'h0000_00FF, 1'b1);
      chk("t5_drained", 256'(rd_ptr), 256'(fq.size()));

      // async reset mid-packet with a beat held on the output
      base = b_data.size();
      p0 = rd_ptr;
      m_axis.tready = 1'b0;
      send(9, 64, 4'hF, 11);
      for (int i = 0; i < 100 && rd_ptr - p0 < 15; i++) step();
      chk("t6_pops", 256'(rd_ptr - p0), 256'(15));
      chk("t6_tvalid_pre", 256'(m_axis.tvalid), 256'(1));
      #1 axi_reset = 1'b1;
      #1 chk("t6_tvalid_async", 256'(m_axis.tvalid), 256'(0));
      #1 axi_reset = 1'b0;
      m_axis.tready = 1'b1;
      send(10, 8, 4'hF, 99);
      wait_beats("t6_count", base, 1);
      chk_beat("t6_b0", base, 10, 8, 0, 32'h0000_00FF, 1'b1);

      // same scenario with the synchronous soft reset
      base = b_data.size();
      p0 = rd_ptr;
      m_axis.tready = 1'b0;
      send(11, 64, 4'hF, 11);
      for (int i = 0; i < 100 && rd_ptr - p0 < 15; i++) step();
      chk("t7_pops", 256'(rd_ptr - p0), 256'(15));
      sw_rst = 1'b1;
      #1 chk("t7_tvalid_pre_edge", 256'(m_axis.tvalid), 256'(1));
      step();
      chk("t7_tvalid_post_edge", 256'(m_axis.tvalid), 256'(0));
      sw_rst = 1'b0;
      m_axis.tready = 1'b1;
      send(12, 8, 4'hF, 99);
      wait_beats("t7_count", base, 1);
      chk_beat("t7_b0", base, 12, 8, 0, 32'h0000_00FF, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
